// File: rtl/issue_scheduler_if.sv
// Handshake bundle between the reservation stations, the issue scheduler and the FU/CDB stage.
// master drives stations/FU side; slave is the scheduler.
interface issue_scheduler_if #(
    parameter int unsigned NUM_RS       = 4,
    parameter int unsigned RS_IDX_WIDTH = 2,
    parameter int unsigned ROB_TAG_LEN  = 6,
    parameter int unsigned XLEN         = 32
);
    logic [NUM_RS-1:0]                  rs_ready;
    logic [NUM_RS-1:0][ROB_TAG_LEN-1:0] rs_dst_tag;
    logic                               hold;
    logic                               flush;
    logic [XLEN-1:0]                    fu_result;
    logic [NUM_RS-1:0]                  rs_issue;
    logic                               grant_valid;
    logic [RS_IDX_WIDTH-1:0]            grant_idx;
    logic                               wakeup;
    logic [ROB_TAG_LEN-1:0]             wakeup_tag;
    logic [XLEN-1:0]                    wakeup_value;
    logic [3:0]                         inflight;

    modport master (
        output rs_ready, rs_dst_tag, hold, flush, fu_result,
        input  rs_issue, grant_valid, grant_idx, wakeup, wakeup_tag, wakeup_value, inflight
    );

    modport slave (
        input  rs_ready, rs_dst_tag, hold, flush, fu_result,
        output rs_issue, grant_valid, grant_idx, wakeup, wakeup_tag, wakeup_value, inflight
    );
endinterface

// File: rtl/issue_scheduler.sv
// Round-robin issue of NUM_RS reservation stations onto one fixed-latency FU, with a
// latency-matched tag delay line that broadcasts the result back as a wakeup.
module issue_scheduler #(
    parameter int unsigned NUM_RS       = 4,
    parameter int unsigned RS_IDX_WIDTH = 2,
    parameter int unsigned FU_LATENCY   = 1,
    parameter int unsigned ROB_TAG_LEN  = 6,
    parameter int unsigned XLEN         = 32
) (
    input logic              clk,
    input logic              reset,
    issue_scheduler_if.slave bus
);
    localparam logic [RS_IDX_WIDTH:0]   NumRsW  = (RS_IDX_WIDTH + 1)'(NUM_RS);
    localparam logic [RS_IDX_WIDTH-1:0] LastIdx = RS_IDX_WIDTH'(NUM_RS - 1);

    logic [RS_IDX_WIDTH-1:0]                rr_ptr_q, rr_ptr_d;
    logic [NUM_RS-1:0]                      cand;
    logic [NUM_RS-1:0]                      rs_issue;
    logic                                   grant_valid;
    logic [RS_IDX_WIDTH-1:0]                grant_idx;
    logic [RS_IDX_WIDTH:0]                  sum;
    logic [RS_IDX_WIDTH-1:0]                sel;
    logic [FU_LATENCY-1:0]                  valid_q;
    logic [FU_LATENCY-1:0][ROB_TAG_LEN-1:0] tag_q;
    logic [3:0]                             inflight_q, inflight_d;
    logic                                   wakeup;

    // Reset is treated like a flush so nothing issues or wakes while it is asserted.
    always_comb begin
        cand        = bus.rs_ready & ~{NUM_RS{bus.hold | bus.flush | reset}};
        grant_valid = 1'b0;
        grant_idx   = '0;
        rs_issue    = '0;
        sum         = '0;
        sel         = '0;
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            sum = {1'b0, rr_ptr_q} + (RS_IDX_WIDTH + 1)'(i);
            if (sum >= NumRsW) begin
                sum = sum - NumRsW;
            end
            sel = sum[RS_IDX_WIDTH-1:0];
            if (!grant_valid && cand[sel]) begin
                grant_valid = 1'b1;
                grant_idx   = sel;
            end
        end
        if (grant_valid) begin
            rs_issue[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
        end
    end

    assign wakeup     = valid_q[FU_LATENCY-1] & ~bus.flush & ~reset;
    assign inflight_d = bus.flush ? 4'd0 : inflight_q + 4'(grant_valid) - 4'(wakeup);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            valid_q    <= '0;
            tag_q      <= '0;
            inflight_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            valid_q[0] <= grant_valid;
            tag_q[0]   <= bus.rs_dst_tag[grant_idx];
            for (int i = 1; i < FU_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
            // Tags are left stale on flush; only the valids matter.
            if (bus.flush) begin
                valid_q <= '0;
            end
            inflight_q <= inflight_d;
        end
    end

    assign bus.rs_issue     = rs_issue;
    assign bus.grant_valid  = grant_valid;
    assign bus.grant_idx    = grant_idx;
    assign bus.wakeup       = wakeup;
    assign bus.wakeup_tag   = reset ? '0 : tag_q[FU_LATENCY-1];
    assign bus.wakeup_value = wakeup ? bus.fu_result : {XLEN{1'b0}};
    assign bus.inflight     = inflight_q;
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: one instance with FU_LATENCY=1, one with FU_LATENCY=3.
module tb_issue_scheduler;
    localparam int unsigned NRS = 4;
    localparam int unsigned IW  = 2;
    localparam int unsigned TW  = 6;
    localparam int unsigned XW  = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    issue_scheduler_if #(.NUM_RS(NRS), .RS_IDX_WIDTH(IW), .ROB_TAG_LEN(TW), .XLEN(XW)) bus1 ();
    issue_scheduler_if #(.NUM_RS(NRS), .RS_IDX_WIDTH(IW), .ROB_TAG_LEN(TW), .XLEN(XW)) bus3 ();

    issue_scheduler #(
        .NUM_RS(NRS), .RS_IDX_WIDTH(IW), .FU_LATENCY(1), .ROB_TAG_LEN(TW), .XLEN(XW)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    issue_scheduler #(
        .NUM_RS(NRS), .RS_IDX_WIDTH(IW), .FU_LATENCY(3), .ROB_TAG_LEN(TW), .XLEN(XW)
    ) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on dut1, check at the falling edge, then move past the next rising edge.
    task automatic step1(input string n, input logic [3:0] rdy, input logic h, input logic f,
                         input logic [31:0] fu, input logic egv, input logic [1:0] eidx,
                         input logic ewk, input logic [5:0] etag, input logic [3:0] einf);
        logic [3:0] eiss;
        bus1.rs_ready  = rdy;
        bus1.hold      = h;
        bus1.flush     = f;
        bus1.fu_result = fu;
        eiss = egv ? (4'b0001 << eidx) : 4'b0000;
        @(negedge clk);
        check({n, ".gv"}, 64'(bus1.grant_valid), 64'(egv));
        check({n, ".idx"}, 64'(bus1.grant_idx), 64'(eidx));
        check({n, ".issue"}, 64'(bus1.rs_issue), 64'(eiss));
        check({n, ".wk"}, 64'(bus1.wakeup), 64'(ewk));
        if (ewk) check({n, ".tag"}, 64'(bus1.wakeup_tag), 64'(etag));
        check({n, ".val"}, 64'(bus1.wakeup_value), ewk ? 64'(fu) : 64'd0);
        check({n, ".infl"}, 64'(bus1.inflight), 64'(einf));
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input string n, input logic [3:0] rdy, input logic h, input logic f,
                         input logic [31:0] fu, input logic egv, input logic [1:0] eidx,
                         input logic ewk, input logic [5:0] etag, input logic [3:0] einf);
        logic [3:0] eiss;
        bus3.rs_ready  = rdy;
        bus3.hold      = h;
        bus3.flush     = f;
        bus3.fu_result = fu;
        eiss = egv ? (4'b0001 << eidx) : 4'b0000;
        @(negedge clk);
        check({n, ".gv"}, 64'(bus3.grant_valid), 64'(egv));
        check({n, ".idx"}, 64'(bus3.grant_idx), 64'(eidx));
        check({n, ".issue"}, 64'(bus3.rs_issue), 64'(eiss));
        check({n, ".wk"}, 64'(bus3.wakeup), 64'(ewk));
        if (ewk) check({n, ".tag"}, 64'(bus3.wakeup_tag), 64'(etag));
        check({n, ".val"}, 64'(bus3.wakeup_value), ewk ? 64'(fu) : 64'd0);
        check({n, ".infl"}, 64'(bus3.inflight), 64'(einf));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus1.rs_ready = '0; bus1.hold = 1'b0; bus1.flush = 1'b0; bus1.fu_result = 32'h1234_5678;
        bus3.rs_ready = '0; bus3.hold = 1'b0; bus3.flush = 1'b0; bus3.fu_result = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            bus1.rs_dst_tag[k] = 6'(k + 8);
            bus3.rs_dst_tag[k] = 6'(2 * k + 1);
        end

        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst.wk1", 64'(bus1.wakeup), 64'd0);
        check("rst.tag1", 64'(bus1.wakeup_tag), 64'd0);
        check("rst.val1", 64'(bus1.wakeup_value), 64'd0);
        check("rst.infl1", 64'(bus1.inflight), 64'd0);
        check("rst.wk3", 64'(bus3.wakeup), 64'd0);
        check("rst.tag3", 64'(bus3.wakeup_tag), 64'd0);
        check("rst.infl3", 64'(bus3.inflight), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Round robin, all ready; latency 1 so each grant wakes the next cycle.
        step1("rr0", 4'b1111, 0, 0, 32'hA000_0000, 1, 0, 0, 0, 0);
        step1("rr1", 4'b1111, 0, 0, 32'hA000_0001, 1, 1, 1, 8, 1);
        step1("rr2", 4'b1111, 0, 0, 32'hA000_0002, 1, 2, 1, 9, 1);
        step1("rr3", 4'b1111, 0, 0, 32'hA000_0003, 1, 3, 1, 10, 1);
        step1("rr4", 4'b1111, 0, 0, 32'hA000_0004, 1, 0, 1, 11, 1);
        step1("rr5", 4'b0000, 0, 0, 32'hA000_0005, 0, 0, 1, 8, 1);
        // Sparse wrap with pointer at 1.
        step1("sp0", 4'b1001, 0, 0, 32'hB000_0000, 1, 3, 0, 0, 0);
        step1("sp1", 4'b1001, 0, 0, 32'hB000_0001, 1, 0, 1, 11, 1);
        step1("sp2", 4'b1001, 0, 0, 32'hB000_0002, 1, 3, 1, 8, 1);
        // Hold: grant suppressed, delay line still drains, pointer frozen.
        step1("hd0", 4'b0010, 1, 0, 32'hC000_0000, 0, 0, 1, 11, 1);
        step1("hd1", 4'b0010, 1, 0, 32'hC000_0001, 0, 0, 0, 0, 0);
        step1("hd2", 4'b0010, 0, 0, 32'hC000_0002, 1, 1, 0, 0, 0);
        step1("hd3", 4'b1111, 1, 0, 32'hC000_0003, 0, 0, 1, 9, 1);
        step1("hd4", 4'b1111, 1, 0, 32'hC000_0004, 0, 0, 0, 0, 0);
        step1("hd5", 4'b1111, 0, 0, 32'hC000_0005, 1, 2, 0, 0, 0);
        step1("hd6", 4'b0000, 0, 0, 32'hC000_0006, 0, 0, 1, 10, 1);
        // Flush kills the op in flight and blocks the grant.
        step1("fl0", 4'b1111, 0, 0, 32'hD000_0000, 1, 3, 0, 0, 0);
        step1("fl1", 4'b1111, 0, 1, 32'hD000_0001, 0, 0, 0, 0, 1);
        step1("fl2", 4'b0000, 0, 0, 32'hD000_0002, 0, 0, 0, 0, 0);
        step1("fl3", 4'b1111, 0, 0, 32'hD000_0003, 1, 0, 0, 0, 0);

        // Reset mid-flight: no wakeup, pointer returns to 0.
        reset = 1'b1;
        bus1.rs_ready = 4'b1111;
        @(negedge clk);
        check("mr.wk", 64'(bus1.wakeup), 64'd0);
        check("mr.val", 64'(bus1.wakeup_value), 64'd0);
        check("mr.infl", 64'(bus1.inflight), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step1("mr1", 4'b1111, 0, 0, 32'hE000_0001, 1, 0, 0, 0, 0);
        step1("mr2", 4'b0000, 0, 0, 32'hE000_0002, 0, 0, 1, 8, 1);
        step1("mr3", 4'b0000, 0, 0, 32'hE000_0003, 0, 0, 0, 0, 0);

        // Latency 3: tag/value path.
        step3("tv0", 4'b0100, 0, 0, 32'h0000_0000, 1, 2, 0, 0, 0);
        step3("tv1", 4'b0000, 0, 0, 32'h1111_1111, 0, 0, 0, 0, 1);
        step3("tv2", 4'b0000, 0, 0, 32'h2222_2222, 0, 0, 0, 0, 1);
        step3("tv3", 4'b0000, 0, 0, 32'hDEAD_BEEF, 0, 0, 1, 5, 1);
        // Flush with two ops in flight.
        step3("ff0", 4'b1111, 0, 0, 32'hDEAD_BEEF, 1, 3, 0, 0, 0);
        step3("ff1", 4'b1111, 0, 0, 32'h3333_3333, 1, 0, 0, 0, 1);
        step3("ff2", 4'b1111, 0, 1, 32'h4444_4444, 0, 0, 0, 0, 2);
        step3("ff3", 4'b1111, 0, 0, 32'h5555_5555, 1, 1, 0, 0, 0);
        step3("ff4", 4'b0000, 0, 0, 32'h6666_6666, 0, 0, 0, 0, 1);
        step3("ff5", 4'b0000, 0, 0, 32'h7777_7777, 0, 0, 0, 0, 1);
        step3("ff6", 4'b0000, 0, 0, 32'hCAFE_F00D, 0, 0, 1, 3, 1);
        // Flush in the very cycle the op would have woken.
        step3("fw0", 4'b0100, 0, 0, 32'h8888_8888, 1, 2, 0, 0, 0);
        step3("fw1", 4'b0000, 0, 0, 32'h9999_9999, 0, 0, 0, 0, 1);
        step3("fw2", 4'b0000, 0, 0, 32'hAAAA_AAAA, 0, 0, 0, 0, 1);
        step3("fw3", 4'b0000, 0, 1, 32'hBBBB_BBBB, 0, 0, 0, 0, 1);
        step3("fw4", 4'b0000, 0, 0, 32'hCCCC_CCCC, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Issue unit that shares one fixed-latency functional unit between `NUM_RS` reservation stations. Each cycle it picks one ready station by round-robin and drives that station's `issue`. It carries the issued destination tag down a latency-matched delay line. When the result emerges it broadcasts `wakeup`/`wakeup_tag`/`wakeup_value` back to every station. It sits between the reservation stations and the FU/CDB stage.

## Interface
- `NUM_RS`, default 4: number of reservation stations sharing the FU (2..8).
- `RS_IDX_WIDTH`, default 2: width of a station index; must be at least clog2(`NUM_RS`).
- `FU_LATENCY`, default 1: cycles from issue to result (1..8).

Clock/reset: reset `reset`, synchronous, active-high; clock `clk`.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous active-high reset.
- `rs_ready`  in  `NUM_RS`  bit k = station k has a ready instruction (its `insn_ready`).
- `rs_dst_tag`  in  `NUM_RS` x `ROB_TAG_LEN`  destination tag currently offered by station k.
- `hold`  in  1  when high, no new issue this cycle (structural stall).
- `flush`  in  1  discards all in-flight operations.
- `fu_result`  in  `XLEN`  FU result, valid in the cycle the matching op completes.
- `rs_issue`  out  `NUM_RS`  one-hot or zero; drives each station's `issue`.
- `grant_valid`  out  1  an issue is granted this cycle.
- `grant_idx`  out  `RS_IDX_WIDTH`  index of the granted station (FU operand-mux select).
- `wakeup`  out  1  broadcast valid.
- `wakeup_tag`  out  `ROB_TAG_LEN`  tag being woken.
- `wakeup_value`  out  `XLEN`  value for `wakeup_tag`.
- `inflight`  out  4  count of issued ops whose wakeup has not yet been broadcast.

## Operation
**Grant (combinational)**
- Candidates are `rs_ready & ~{NUM_RS{hold|flush}}`.
- Select the first candidate at index >= `rr_ptr`, searching upward and wrapping modulo `NUM_RS`.
- `rs_issue` is one-hot at that index; `grant_valid` = any candidate; `grant_idx` = selected index, 0 when no grant.

**Round-robin pointer**
- On a granted edge: `rr_ptr` <= (`grant_idx`+1) mod `NUM_RS`, so wrap from `NUM_RS`-1 goes to 0.
- No grant: `rr_ptr` unchanged.

**Delay line**
- `FU_LATENCY` stages, each holding {valid, tag}.
- At every edge, stage 0 <= {`grant_valid`, `rs_dst_tag[grant_idx]`}; stage i <= stage i-1.
- `flush`: all stage valids <= 0 at that edge; tags may keep stale values.

**Broadcast**
- `wakeup` = last-stage valid & ~`flush`.
- `wakeup_tag` = last-stage tag.
- `wakeup_value` = `fu_result` when `wakeup`, else 0.

**In-flight counter**
- `inflight` <= `inflight` + `grant_valid` - `wakeup`.
- `flush` sets it to 0, even if a grant is attempted in the same cycle.
- Width 4 covers the maximum of 8.

## Timing
- Reset: all stage valids 0, tags 0; `rr_ptr` 0; `inflight` 0.
- During and after reset: `wakeup`=0, `wakeup_tag`=0, `wakeup_value`=0.
- `rs_issue`, `grant_valid`, `grant_idx` are combinational; they follow inputs and are 0 when `rs_ready`=0.
- Latency: an issue granted in cycle C produces `wakeup` in cycle C+`FU_LATENCY`. With `FU_LATENCY`=1, wakeup comes exactly one cycle after issue, as the stations require.
- Throughput: one issue per cycle; back-to-back issues give back-to-back wakeups.
- A wakeup and a new grant in the same cycle are independent. The station consumes the wakeup at the same edge it accepts the issue.
- `hold` suppresses the grant only; the delay line still advances, and the pointer does not move.
- `flush` in cycle F:
  - no grant and no wakeup in F;
  - ops issued at or before F-1 never wake up;
  - the first post-flush wakeup can come from an issue in F+1.
- Reset mid-operation behaves like `flush` and also returns `rr_ptr` to 0.
- `rs_ready` and `rs_dst_tag` must be stable at the clock edge; tag is sampled at the grant edge.

## Test plan
- **Round-robin, all ready:** `NUM_RS`=4, `rs_ready`=4'b1111 for 5 cycles after reset -> `grant_idx` sequence 0,1,2,3,0.
- **Sparse wrap:** `rs_ready`=4'b1001 with `rr_ptr`=1 -> grant 3, then 0, then 3.
- **Tag/value path:** `FU_LATENCY`=3; issue station 2 with `rs_dst_tag[2]`=5 in cycle 10; `fu_result`=32'hDEAD_BEEF in cycle 13 -> `wakeup`=1, `wakeup_tag`=5, `wakeup_value`=32'hDEAD_BEEF in cycle 13 only.
- **Hold:** `rs_ready`=4'b0010, `hold`=1 for 2 cycles -> `rs_issue`=0 and `rr_ptr` unchanged; grant 1 in the first cycle after `hold` drops.
- **Flush mid-flight:** `FU_LATENCY`=2; issue in cycles 0 and 1, `flush` in cycle 2 -> no wakeup in cycles 2 or 3, `inflight`=0 in cycle 3; a new issue in cycle 3 wakes up in cycle 5.
- **Counter under overlap:** `FU_LATENCY`=1; continuous issue for 6 cycles -> `inflight` holds at 1; after `rs_ready` drops it returns to 0 one cycle later.
